// File: rtl/axi_read_arbiter.sv
// Shares one AXI4 read channel between instruction fetch and data load.
// One outstanding single-beat read at a time, round-robin on contention.
module axi_read_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int ID_W   = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              inst_req,
   input  logic [ADDR_W-1:0] inst_addr,
   output logic              inst_ready,
   output logic [DATA_W-1:0] inst_rdata,
   output logic              inst_rvalid,
   input  logic              data_req,
   input  logic [ADDR_W-1:0] data_addr,
   input  logic [2:0]        data_size,
   output logic              data_ready,
   output logic [DATA_W-1:0] data_rdata,
   output logic              data_rvalid,
   output logic [ID_W-1:0]   arid,
   output logic [ADDR_W-1:0] araddr,
   output logic [7:0]        arlen,
   output logic [2:0]        arsize,
   output logic [1:0]        arburst,
   output logic              arvalid,
   input  logic              arready,
   input  logic [ID_W-1:0]   rid,
   input  logic [DATA_W-1:0] rdata,
   input  logic [1:0]        rresp,
   input  logic              rlast,
   input  logic              rvalid,
   output logic              rready,
   output logic              busy
);

   // state  | meaning
   // S_IDLE | no transaction, arbitrating between requesters
   // S_ADDR | AR beat presented, waiting for arready
   // S_RESP | waiting for the single R beat
   typedef enum logic [1:0] {S_IDLE, S_ADDR, S_RESP} state_t;

   localparam logic OWN_INST = 1'b0;
   localparam logic OWN_DATA = 1'b1;

   state_t            state_q, state_d;
   logic              owner_q, owner_d;
   logic              last_grant_q, last_grant_d;
   logic              discard_q, discard_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [2:0]        size_q, size_d;
   logic [DATA_W-1:0] inst_rdata_q, inst_rdata_d;
   logic [DATA_W-1:0] data_rdata_q, data_rdata_d;
   logic              inst_rvalid_q, inst_rvalid_d;
   logic              data_rvalid_q, data_rvalid_d;
   logic              inst_elig, data_elig;
   logic              unused_r;

   // Single-beat reads are assumed, so the R sideband is ignored.
   assign unused_r = ^{rid, rresp, rlast};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         owner_q       <= OWN_INST;
         last_grant_q  <= OWN_DATA;
         discard_q     <= 1'b0;
         addr_q        <= '0;
         size_q        <= '0;
         inst_rdata_q  <= '0;
         data_rdata_q  <= '0;
         inst_rvalid_q <= 1'b0;
         data_rvalid_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         owner_q       <= owner_d;
         last_grant_q  <= last_grant_d;
         discard_q     <= discard_d;
         addr_q        <= addr_d;
         size_q        <= size_d;
         inst_rdata_q  <= inst_rdata_d;
         data_rdata_q  <= data_rdata_d;
         inst_rvalid_q <= inst_rvalid_d;
         data_rvalid_q <= data_rvalid_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      owner_d       = owner_q;
      last_grant_d  = last_grant_q;
      discard_d     = discard_q;
      addr_d        = addr_q;
      size_d        = size_q;
      inst_rdata_d  = inst_rdata_q;
      data_rdata_d  = data_rdata_q;
      inst_rvalid_d = 1'b0;
      data_rvalid_d = 1'b0;
      inst_ready    = 1'b0;
      data_ready    = 1'b0;
      inst_elig     = inst_req && !flush;
      data_elig     = data_req;

      case (state_q)
         S_IDLE: begin
            discard_d = 1'b0;
            // Ready is gated by rst so nothing is acknowledged during reset.
            if (!rst) begin
               if (inst_elig && (!data_elig || last_grant_q == OWN_DATA)) begin
                  inst_ready = 1'b1;
               end else if (data_elig) begin
                  data_ready = 1'b1;
               end
            end
            if (inst_ready) begin
               owner_d      = OWN_INST;
               addr_d       = inst_addr;
               size_d       = 3'b010;
               last_grant_d = OWN_INST;
               state_d      = S_ADDR;
            end else if (data_ready) begin
               owner_d      = OWN_DATA;
               addr_d       = data_addr;
               size_d       = data_size;
               last_grant_d = OWN_DATA;
               state_d      = S_ADDR;
            end
         end
         S_ADDR: begin
            if (owner_q == OWN_INST && flush) discard_d = 1'b1;
            if (arready) state_d = S_RESP;
         end
         S_RESP: begin
            if (owner_q == OWN_INST && flush) discard_d = 1'b1;
            if (rvalid) begin
               state_d   = S_IDLE;
               discard_d = 1'b0;
               if (owner_q == OWN_DATA) begin
                  data_rdata_d  = rdata;
                  data_rvalid_d = 1'b1;
               end else begin
                  inst_rdata_d  = rdata;
                  // A flush in the handshake cycle itself also kills the pulse.
                  inst_rvalid_d = !(discard_q || flush);
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign arvalid     = (state_q == S_ADDR);
   assign rready      = (state_q == S_RESP);
   assign busy        = (state_q != S_IDLE);
   assign araddr      = addr_q;
   assign arsize      = size_q;
   assign arid        = {{(ID_W-1){1'b0}}, owner_q};
   assign arlen       = 8'd0;
   assign arburst     = 2'b01;
   assign inst_rdata  = inst_rdata_q;
   assign inst_rvalid = inst_rvalid_q;
   assign data_rdata  = data_rdata_q;
   assign data_rvalid = data_rvalid_q;

endmodule
